fetch_align_8085: RTL and testbench
===================================

# fetch_align_8085

Instruction fetch and alignment stage for the pipelined 8085 core. It streams bytes from instruction memory through a small byte queue and assembles variable-length 8085 instructions (1, 2 or 3 bytes). It presents each complete instruction to the decode stage through a valid/ready handshake. It also handles branch redirects and the HLT stop condition.

## Interface
Parameters:
- `QDEPTH`, 4: byte-queue depth. Must be at least 3 and a power of two.
- `RESET_PC`, 16'h0000: fetch address after reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `imem_rd`, output, 1: instruction-memory read strobe.
- `imem_addr`, output, 16: byte address for the read.
- `imem_data`, input, 8: read data, valid exactly 1 cycle after an `imem_rd` cycle.
- `redirect`, input, 1: taken branch, jump, call or return from execute; flushes the stage.
- `redirect_pc`, input, 16: new fetch address, sampled when `redirect`=1.
- `id_ready`, input, 1: decode stage can accept an instruction this cycle.
- `id_valid`, output, 1: a complete instruction is present on the `id_*` outputs.
- `id_opcode`, output, 8: instruction byte 0.
- `id_op1`, output, 8: byte 1. Forced to 0 when `id_len` < 2.
- `id_op2`, output, 8: byte 2. Forced to 0 when `id_len` < 3.
- `id_len`, output, 2: instruction length, 1 to 3.
- `id_pc`, output, 16: address of `id_opcode`.
- `halted`, output, 1: the stage is in state HALTED.

## Operation
- **State machine, 2 states:**
  - RUN to HALTED: when an instruction with opcode 8'h76 (HLT) completes handshake.
  - HALTED to RUN: only on `redirect`.
  - In HALTED: `imem_rd`=0 and `id_valid`=0.
- **Byte queue:** circular FIFO of `QDEPTH` bytes with a head pointer, a tail pointer and a count.
  - A returning byte is written at the tail when the in-flight flag is set and no flush is in effect.
  - `head_pc` holds the address of the head byte.
- **Fetch issue:** `imem_rd`=1 in RUN when `count + inflight < QDEPTH` and `redirect`=0.
  - `imem_addr` = `fpc`.
  - `fpc` increments by 1 per issued read and wraps from 16'hFFFF to 16'h0000.
- **Length decode:** a combinational function of the head byte.
  - 3-byte opcodes: 01, 11, 21, 31, 22, 2A, 32, 3A, C3, CD, C2, CA, D2, DA, E2, EA, F2, FA, C4, CC, D4, DC, E4, EC, F4, FC.
  - 2-byte opcodes: 06, 0E, 16, 1E, 26, 2E, 36, 3E, C6, CE, D6, DE, E6, EE, F6, FE, D3, DB.
  - All other opcodes are 1 byte.
- **Issue to decode:** `id_valid` = RUN and `count` >= `id_len`.
  - The `id_*` outputs are taken combinationally from the queue head.
  - Outputs hold stable while `id_valid`=1 and `id_ready`=0.
  - On handshake (`id_valid` and `id_ready`): head advances by `id_len`, `count` decreases by `id_len`, and `head_pc` increases by `id_len`, modulo 2^16.
- **Redirect (highest priority):**
  - Queue is cleared and `head_pc` = `fpc` = `redirect_pc`.
  - The in-flight byte is discarded: it is not written on its return cycle.
  - No read is issued in the redirect cycle.
  - A handshake in the same cycle as `redirect` still completes; then the flush applies.
- **Simultaneous write and consume:** `count` = `count` + 1 − `id_len`. The queue never overflows because of the issue rule.

## Timing
- **Reset values:** `imem_rd`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_opcode`/`id_op1`/`id_op2`=0, `id_len`=1, `id_pc`=`RESET_PC`, `halted`=0, queue empty, state RUN.
- **Reset release to first instruction:**
  - Cycle 0 after reset release: `imem_rd`=1, addr `RESET_PC`.
  - Byte captured at the end of cycle 1.
  - A 1-byte instruction is valid in cycle 2.
  - A 3-byte instruction is valid in cycle 4.
- **Steady state:** 1 byte per cycle, so an n-byte instruction stream issues at 1 instruction per n cycles.
- **Redirect latency:**
  - `redirect` in cycle t gives `imem_rd` with `redirect_pc` in cycle t+1.
  - First new instruction is valid no earlier than t+3.
  - `id_valid`=0 in cycle t+1.
- **Asynchronous reset mid-operation:** clears state immediately, including the in-flight flag. Data returning after reset is ignored.

## Structure
- **Shared package** `pkg_8085`:
  - Opcode constants, including `OP_HLT` = 8'h76.
  - The `instr_len_8085` length function.
  - State encoding RUN/HALTED.
- **Sub-module** `byte_queue_8085`: parameterised circular FIFO.
  - Push of 1 byte.
  - Pop of 0 to 3 bytes per cycle.
  - Flush.
  - Three-byte peek.

## Test plan
- **Reset and sequential fetch.** Memory from 0 holds 3E 05 80 76 (MVI A,5; ADD B; HLT).
  - Decode emits len=2 at pc 0 (op1=05), then len=1 at pc 2, then len=1 at pc 3.
  - After the HLT handshake, `halted`=1 and `imem_rd` stays 0 for 20 cycles.
- **Back-pressure.** Hold `id_ready`=0 for 10 cycles on stream C3 34 12.
  - `id_opcode`=C3, op1=34, op2=12 and `id_pc`=0 stay stable.
  - `count` never exceeds `QDEPTH` and `imem_rd` drops once the queue is full.
- **Redirect mid-instruction.** Assert `redirect` with `redirect_pc`=16'h0040 while a 3-byte instruction is only partially queued.
  - Stale bytes never appear on the decode outputs.
  - The next valid instruction has `id_pc`=16'h0040.
- **Redirect with handshake in the same cycle.** The current instruction is consumed exactly once, then the flush applies.
- **Wrap-around.** Reset with `RESET_PC`=16'hFFFE; memory at FFFE, FFFF, 0000 holds 01 CD AB (LXI B).
  - Output: len=3, op1=CD, op2=AB, `id_pc`=FFFE.
  - The next `id_pc` is 0001.
- **Asynchronous reset during an active stream.**
  - All outputs take their reset values without waiting for a clock edge.
  - Fetch restarts at `RESET_PC` on the first cycle after reset release.

Source files
------------

// File: rtl/fetch_align_8085_pkg.sv
// Shared definitions for the 8085 fetch/align stage: opcode constants,
// stage states and the instruction-length decode.
package pkg_8085;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_HLT = 8'h76;
    localparam logic [7:0] OP_JMP = 8'hC3;

    // Length is fully determined by the opcode byte; anything unlisted is 1 byte.
    function automatic logic [1:0] instr_len_8085(input logic [7:0] op);
        case (op)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
            8'hC3, 8'hCD, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA,
            8'hF2, 8'hFA, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC,
            8'hF4, 8'hFC:
                return 2'd3;
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hD3, 8'hDB:
                return 2'd2;
            default:
                return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_align_8085_byte_queue.sv
// Circular byte FIFO: one push per cycle, pop of 0..3 bytes, flush and a
// three-byte peek at the head.
module byte_queue_8085
    import pkg_8085::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic [1:0]               pop_cnt,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               peek0,
    output logic [7:0]               peek1,
    output logic [7:0]               peek2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign peek0 = mem[head];
    assign peek1 = mem[head + PW'(1)];
    assign peek2 = mem[head + PW'(2)];

    // Storage is cleared on reset so the head byte reads as a 1-byte NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= OP_NOP;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + PW'(1);
            end
            head  <= head + PW'(pop_cnt);
            count <= count + CW'(push) - CW'(pop_cnt);
        end
    end

endmodule

// File: rtl/fetch_align_8085.sv
// 8085 instruction fetch and alignment: streams bytes into a small queue and
// hands complete 1..3 byte instructions to decode, with redirect and HLT.
module fetch_align_8085
    import pkg_8085::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [7:0]  imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [7:0]  id_opcode,
    output logic [7:0]  id_op1,
    output logic [7:0]  id_op2,
    output logic [1:0]  id_len,
    output logic [15:0] id_pc,
    output logic        halted
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [15:0]   fpc;
    logic [15:0]   head_pc;
    logic          inflight;
    logic          fetch_ok;
    logic          handshake;
    logic [CW-1:0] count;
    logic [7:0]    peek0;
    logic [7:0]    peek1;
    logic [7:0]    peek2;
    logic [1:0]    q_len;

    byte_queue_8085 #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight && !redirect),
        .push_data (imem_data),
        .pop_cnt   (handshake ? q_len : 2'd0),
        .flush     (redirect),
        .count     (count),
        .peek0     (peek0),
        .peek1     (peek1),
        .peek2     (peek2)
    );

    assign q_len     = instr_len_8085(peek0);
    assign handshake = id_valid && id_ready;
    assign fetch_ok  = (state == ST_RUN) && !redirect
                       && ((count + CW'(inflight)) < CW'(QDEPTH));

    assign imem_addr = fpc;
    assign id_opcode = peek0;
    assign id_op1    = (q_len >= 2'd2) ? peek1 : 8'h00;
    assign id_op2    = (q_len == 2'd3) ? peek2 : 8'h00;
    assign id_len    = q_len;
    assign id_pc     = head_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect overrides everything, including a HLT consumed in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (handshake && peek0 == OP_HLT) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
        if (redirect) begin
            state_nxt = ST_RUN;
        end
    end

    // The read strobe is held low while reset is asserted so it shows 0 immediately.
    always_comb begin
        imem_rd  = fetch_ok && reset;
        id_valid = (state == ST_RUN) && (count >= CW'(q_len));
        halted   = (state == ST_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= fetch_ok;
            if (redirect) begin
                fpc     <= redirect_pc;
                head_pc <= redirect_pc;
            end else begin
                if (fetch_ok) fpc <= fpc + 16'd1;
                if (handshake) head_pc <= head_pc + 16'(q_len);
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_8085.sv
// Directed, table-driven bench for fetch_align_8085 with hand-computed
// per-cycle expectations plus an asynchronous-reset sequence.
module tb_fetch_align_8085;

    typedef struct {
        logic        rdr;
        logic [15:0] rpc;
        logic        rdy;
        logic        hlt;
        logic        rd;
        logic [15:0] addr;
        logic        vld;
        logic [7:0]  op;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic [15:0] pc;
    } vec_t;

    logic        clk;
    logic        reset_a;
    logic        reset_b;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        use_b;

    logic        rd_a, rd_b, vld_a, vld_b, hlt_a, hlt_b;
    logic [15:0] addr_a, addr_b, pc_a, pc_b;
    logic [7:0]  data_a, data_b, op_a, op_b, op1_a, op1_b, op2_a, op2_b;
    logic [1:0]  len_a, len_b;

    logic [7:0]  mem [0:65535];
    vec_t        vecs[$];
    int          compared;
    int          mismatched;

    fetch_align_8085 #(.QDEPTH(4), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .reset(reset_a), .imem_rd(rd_a), .imem_addr(addr_a),
        .imem_data(data_a), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(vld_a), .id_opcode(op_a), .id_op1(op1_a),
        .id_op2(op2_a), .id_len(len_a), .id_pc(pc_a), .halted(hlt_a)
    );

    fetch_align_8085 #(.QDEPTH(4), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .reset(reset_b), .imem_rd(rd_b), .imem_addr(addr_b),
        .imem_data(data_b), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(vld_b), .id_opcode(op_b), .id_op1(op1_b),
        .id_op2(op2_b), .id_len(len_b), .id_pc(pc_b), .halted(hlt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_b(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'h01;
            16'hFFFF: return 8'hCD;
            16'h0000: return 8'hAB;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rd_a) data_a <= mem[addr_a];
        if (rd_b) data_b <= mem_b(addr_b);
    end

    function automatic vec_t mk(input logic rdr, input logic [15:0] rpc, input logic rdy,
                                input logic hlt, input logic rd, input logic [15:0] addr,
                                input logic vld, input logic [7:0] op, input logic [7:0] op1,
                                input logic [7:0] op2, input logic [1:0] len,
                                input logic [15:0] pc);
        vec_t v;
        v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.hlt = hlt; v.rd = rd; v.addr = addr;
        v.vld = vld; v.op = op; v.op1 = op1; v.op2 = op2; v.len = len; v.pc = pc;
        return v;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s (row %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        redirect    = v.rdr;
        redirect_pc = v.rpc;
        id_ready    = v.rdy;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkField("halted", idx, use_b ? 16'(hlt_b) : 16'(hlt_a), 16'(v.hlt));
        checkField("imem_rd", idx, use_b ? 16'(rd_b) : 16'(rd_a), 16'(v.rd));
        if (v.rd) checkField("imem_addr", idx, use_b ? addr_b : addr_a, v.addr);
        checkField("id_valid", idx, use_b ? 16'(vld_b) : 16'(vld_a), 16'(v.vld));
        if (v.vld) begin
            checkField("id_opcode", idx, use_b ? 16'(op_b) : 16'(op_a), 16'(v.op));
            checkField("id_op1", idx, use_b ? 16'(op1_b) : 16'(op1_a), 16'(v.op1));
            checkField("id_op2", idx, use_b ? 16'(op2_b) : 16'(op2_a), 16'(v.op2));
            checkField("id_len", idx, use_b ? 16'(len_b) : 16'(len_a), 16'(v.len));
            checkField("id_pc", idx, use_b ? pc_b : pc_a, v.pc);
        end
    endtask

    // Rows start on the negedge where reset was released (cycle 0).
    task automatic runRows(input int first, input int last);
        for (int i = first; i < last; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(i, vecs[i]);
            @(negedge clk);
        end
    endtask

    task automatic resetA();
        @(negedge clk);
        reset_a = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    int s1, s2, s3, s4;

    initial begin
        compared = 0; mismatched = 0; use_b = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0; id_ready = 1'b0;
        data_a = 8'h00; data_b = 8'h00;

        // Test 1: MVI A,5 / ADD B / HLT, then 20 halted cycles and a redirect out.
        s1 = vecs.size();
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0002, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0003, 1, 8'h3E, 8'h05, 8'h00, 2, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0004, 1, 8'h80, 8'h00, 8'h00, 1, 16'h0002));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0005, 1, 8'h76, 8'h00, 8'h00, 1, 16'h0003));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
        // Test 2: JMP 1234 under 10+ cycles of back-pressure.
        s2 = vecs.size();
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0002, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0003, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hC3, 8'h34, 8'h12, 3, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'hC3, 8'h34, 8'h12, 3, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0004, 1, 8'h00, 8'h00, 8'h00, 1, 16'h0003));
        // Test 3: redirect mid LXI H, then redirect together with a handshake.
        s3 = vecs.size();
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0040, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0040, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0041, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0042, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0043, 1, 8'h3E, 8'h77, 8'h00, 2, 16'h0040));
        vecs.push_back(mk(1, 16'h0080, 1, 0, 0, 0, 1, 8'h80, 8'h00, 8'h00, 1, 16'h0042));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0080, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0081, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0082, 1, 8'h2F, 8'h00, 8'h00, 1, 16'h0080));
        // Test 4: LXI B straddling the 16-bit address wrap (second instance).
        s4 = vecs.size();
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'hFFFE, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'h01, 8'hCD, 8'hAB, 3, 16'hFFFE));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0002, 1, 8'h00, 8'h00, 8'h00, 1, 16'h0001));

        clearMem();
        mem[0] = 8'h3E; mem[1] = 8'h05; mem[2] = 8'h80; mem[3] = 8'h76;
        #1;
        // Reset values before any release.
        checkField("reset imem_rd", -1, 16'(rd_a), 16'h0);
        checkField("reset imem_addr", -1, addr_a, 16'h0000);
        checkField("reset id_valid", -1, 16'(vld_a), 16'h0);
        checkField("reset id_len", -1, 16'(len_a), 16'h1);
        checkField("reset id_pc", -1, pc_a, 16'h0000);
        checkField("reset halted", -1, 16'(hlt_a), 16'h0);
        resetA();
        runRows(s1, s2);

        clearMem();
        mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
        resetA();
        runRows(s2, s3);

        clearMem();
        mem[0] = 8'h21; mem[1] = 8'hAA; mem[2] = 8'hBB;
        mem[16'h40] = 8'h3E; mem[16'h41] = 8'h77; mem[16'h42] = 8'h80; mem[16'h43] = 8'h3C;
        mem[16'h80] = 8'h2F;
        resetA();
        runRows(s3, s4);

        use_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        runRows(s4, vecs.size());
        use_b = 1'b0;

        // Asynchronous reset in the middle of a running stream.
        clearMem();
        mem[0] = 8'h2F; mem[1] = 8'h3C; mem[2] = 8'h80;
        resetA();
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_a = 1'b0;
        #1;
        checkField("async imem_rd", -2, 16'(rd_a), 16'h0);
        checkField("async imem_addr", -2, addr_a, 16'h0000);
        checkField("async id_valid", -2, 16'(vld_a), 16'h0);
        checkField("async id_opcode", -2, 16'(op_a), 16'h00);
        checkField("async id_op1", -2, 16'(op1_a), 16'h00);
        checkField("async id_op2", -2, 16'(op2_a), 16'h00);
        checkField("async id_len", -2, 16'(len_a), 16'h1);
        checkField("async id_pc", -2, pc_a, 16'h0000);
        checkField("async halted", -2, 16'(hlt_a), 16'h0);
        @(negedge clk);
        reset_a = 1'b1;
        #1;
        checkField("restart imem_rd", -3, 16'(rd_a), 16'h1);
        checkField("restart imem_addr", -3, addr_a, 16'h0000);
        @(negedge clk); #1;
        checkField("restart cyc1 id_valid", -3, 16'(vld_a), 16'h0);
        @(negedge clk); #1;
        checkField("restart cyc2 id_valid", -3, 16'(vld_a), 16'h1);
        checkField("restart cyc2 id_opcode", -3, 16'(op_a), 16'h2F);
        checkField("restart cyc2 id_pc", -3, pc_a, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
